// File: rtl/mem_arbiter.sv
// Two-master arbiter for the memory mapper bus port with in-order read routing.
// Define MEM_ARBITER_FIXED_PRIORITY_EN to let m1 always win contests.
module mem_arbiter #(
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        m0_ready,
   output logic        m1_ready,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m0_write_data,
   input  logic [31:0] m1_write_data,
   input  logic [3:0]  m0_byte_enable,
   input  logic [3:0]  m1_byte_enable,
   input  logic        m0_write_req,
   input  logic        m1_write_req,
   input  logic        m0_read_req,
   input  logic        m1_read_req,
   output logic [31:0] m0_read_data,
   output logic [31:0] m1_read_data,
   output logic        m0_read_data_valid,
   output logic        m1_read_data_valid,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_write_data,
   output logic [3:0]  mem_byte_enable,
   output logic        mem_write_req,
   output logic        mem_read_req,
   input  logic [31:0] mem_read_data,
   input  logic        mem_read_data_valid,
   output logic        orphan_error
);

   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CW = PW + 1;

   logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]              count_q, count_d;
   logic [MAX_OUTSTANDING-1:0] id_q, id_d;
   logic                       last_grant_q, last_grant_d;
   logic                       orphan_q, orphan_d;

   logic req0, req1, any_req, grant;
   logic g_rd, g_wr, fifo_full, accept;
   logic push, pop, head;

   // Pick a master, gate the accept and forward its fields downstream
   always_comb begin
      req0 = m0_write_req | m0_read_req;
      req1 = m1_write_req | m1_read_req;
      any_req = req0 | req1;
      grant = 1'b0;
      if (req0 && req1) begin
`ifdef MEM_ARBITER_FIXED_PRIORITY_EN
         grant = 1'b1;
`else
         grant = ~last_grant_q;
`endif
      end else if (req1) begin
         grant = 1'b1;
      end
      g_rd = grant ? m1_read_req : m0_read_req;
      g_wr = grant ? m1_write_req : m0_write_req;
      fifo_full = (count_q == CW'(MAX_OUTSTANDING));
      accept = any_req & mem_ready & (~g_rd | ~fifo_full);
      m0_ready = accept & ~grant;
      m1_ready = accept & grant;
      mem_addr = 32'h0;
      mem_write_data = 32'h0;
      mem_byte_enable = 4'h0;
      if (any_req) begin
         mem_addr = grant ? m1_addr : m0_addr;
         mem_write_data = grant ? m1_write_data : m0_write_data;
         mem_byte_enable = grant ? m1_byte_enable : m0_byte_enable;
      end
      mem_write_req = accept & g_wr;
      mem_read_req = accept & g_rd;
   end

   // Track outstanding read IDs and route each response to its owner
   always_comb begin
      push = accept & g_rd;
      pop = mem_read_data_valid & (count_q != '0);
      head = id_q[rd_ptr_q];
      id_d = id_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d = count_q;
      if (push) begin
         id_d[wr_ptr_q] = grant;
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
      last_grant_d = accept ? grant : last_grant_q;
      orphan_d = orphan_q | (mem_read_data_valid & (count_q == '0));
      m0_read_data_valid = pop & ~head;
      m1_read_data_valid = pop & head;
      m0_read_data = (pop & ~head) ? mem_read_data : 32'h0;
      m1_read_data = (pop & head) ? mem_read_data : 32'h0;
      orphan_error = orphan_q;
   end

   // State registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q <= '0;
         id_q <= '0;
         last_grant_q <= 1'b1;
         orphan_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q <= count_d;
         id_q <= id_d;
         last_grant_q <= last_grant_d;
         orphan_q <= orphan_d;
      end
   end

endmodule
